// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU and its two-port arbiter:
// ALU control codes (including the alternate encodings) and the arbiter state enum.
package alu_pkg;

    localparam logic [3:0] ALU_ADD      = 4'b0000;
    localparam logic [3:0] ALU_SUB      = 4'b1000;
    localparam logic [3:0] ALU_OR       = 4'b0110;
    localparam logic [3:0] ALU_OR_ALT   = 4'b1110;
    localparam logic [3:0] ALU_AND      = 4'b0111;
    localparam logic [3:0] ALU_AND_ALT  = 4'b1111;
    localparam logic [3:0] ALU_XOR      = 4'b0100;
    localparam logic [3:0] ALU_XOR_ALT  = 4'b1100;
    localparam logic [3:0] ALU_SLT      = 4'b0010;
    localparam logic [3:0] ALU_SLTU     = 4'b1010;
    localparam logic [3:0] ALU_SLL      = 4'b0001;
    localparam logic [3:0] ALU_SLL_ALT  = 4'b1001;
    localparam logic [3:0] ALU_LUI      = 4'b0011;
    localparam logic [3:0] ALU_LUI_ALT  = 4'b1011;
    localparam logic [3:0] ALU_SRL      = 4'b0101;
    localparam logic [3:0] ALU_SRA      = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU. Less is only meaningful for SLT/SLTU; for those two
// ops Zero reports A-B == 0 rather than whether the 0/1 output is zero.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALUctr,
    output logic [31:0] ALUout,
    output logic        Zero,
    output logic        Less
);

    logic [31:0] diff;
    logic        lt_signed;
    logic        lt_unsigned;
    logic        is_compare;

    assign diff        = A - B;
    assign lt_signed   = $signed(A) < $signed(B);
    assign lt_unsigned = A < B;
    assign is_compare  = (ALUctr == ALU_SLT) || (ALUctr == ALU_SLTU);

    // Every 4-bit code is decoded; shifts use only the low five bits of B.
    always_comb begin
        ALUout = 32'd0;
        Less   = 1'b0;
        case (ALUctr)
            ALU_ADD:              ALUout = A + B;
            ALU_SUB:              ALUout = diff;
            ALU_SLL, ALU_SLL_ALT: ALUout = A << B[4:0];
            ALU_SLT: begin
                ALUout = {31'd0, lt_signed};
                Less   = lt_signed;
            end
            ALU_SLTU: begin
                ALUout = {31'd0, lt_unsigned};
                Less   = lt_unsigned;
            end
            ALU_LUI, ALU_LUI_ALT: ALUout = B;
            ALU_XOR, ALU_XOR_ALT: ALUout = A ^ B;
            ALU_SRL:              ALUout = A >> B[4:0];
            ALU_SRA:              ALUout = 32'($signed(A) >>> B[4:0]);
            ALU_OR, ALU_OR_ALT:   ALUout = A | B;
            ALU_AND, ALU_AND_ALT: ALUout = A & B;
            default:              ALUout = 32'd0;
        endcase
    end

    assign Zero = is_compare ? (diff == 32'd0) : (ALUout == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: round-robin (or fixed)
// arbitration, registered operands, one op in flight, result held until accepted.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctr,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctr,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_less
);

    arb_state_t  state;
    arb_state_t  state_next;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_ctr;
    logic        owner;
    logic        last_grant;

    logic [31:0] res_result;
    logic        res_zero;
    logic        res_less;

    logic        winner;
    logic        accept;
    logic        rsp_handshake;

    logic [31:0] alu_out;
    logic        alu_zero;
    logic        alu_less;

    // On a tie the port not granted last wins; a lone valid port always wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = RR ? ~last_grant : 1'b0;
        end else begin
            winner = req1_valid;
        end
    end

    assign accept        = (state == IDLE) && (req0_valid || req1_valid);
    assign rsp_handshake = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)        state_next = EXEC;
            EXEC:                       state_next = RESP;
            RESP:    if (rsp_handshake) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !winner;
        req1_ready = accept &&  winner;
        rsp0_valid = (state == RESP) && !owner;
        rsp1_valid = (state == RESP) &&  owner;
    end

    // last_grant resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            op_ctr     <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            res_result <= 32'd0;
            res_zero   <= 1'b0;
            res_less   <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= winner ? req1_a   : req0_a;
                op_b       <= winner ? req1_b   : req0_b;
                op_ctr     <= winner ? req1_ctr : req0_ctr;
                owner      <= winner;
                last_grant <= winner;
            end
            if (state == EXEC) begin
                res_result <= alu_out;
                res_zero   <= alu_zero;
                res_less   <= alu_less;
            end
        end
    end

    alu u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUctr (op_ctr),
        .ALUout (alu_out),
        .Zero   (alu_zero),
        .Less   (alu_less)
    );

    assign rsp_result = res_result;
    assign rsp_zero   = res_zero;
    assign rsp_less   = res_less;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctr, req1_ctr;
    logic        rsp0_ready, rsp1_ready;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_less;

    logic        fx_req0_ready, fx_req1_ready, fx_rsp0_valid, fx_rsp1_valid;
    logic [31:0] fx_rsp_result;
    logic        fx_rsp_zero, fx_rsp_less;

    typedef struct {
        logic        port;
        logic [31:0] result;
        logic        zero;
        logic        less;
    } exp_t;

    exp_t sb[$];
    int   tests_run;
    int   tests_failed;

    alu_arbiter #(.RR(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctr   (req0_ctr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctr   (req1_ctr),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_less   (rsp_less)
    );

    // Fixed-priority instance sharing the same stimulus.
    alu_arbiter #(.RR(1'b0)) dut_fx (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (fx_req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctr   (req0_ctr),
        .req1_valid (req1_valid),
        .req1_ready (fx_req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctr   (req1_ctr),
        .rsp0_valid (fx_rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (fx_rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (fx_rsp_result),
        .rsp_zero   (fx_rsp_zero),
        .rsp_less   (fx_rsp_less)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic port, input logic [31:0] result, input logic zero, input logic less);
        exp_t e;
        e.port   = port;
        e.result = result;
        e.zero   = zero;
        e.less   = less;
        return e;
    endfunction

    // Offer one operation on a single port, wait for its grant, push the expected response.
    task automatic applyStimulus(input logic port, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] ctr, input logic [31:0] exp_result,
                                 input logic exp_zero, input logic exp_less);
        logic granted;
        if (port == 1'b0) begin
            req0_a = a; req0_b = b; req0_ctr = ctr; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_ctr = ctr; req1_valid = 1'b1;
        end
        granted = 1'b0;
        for (int i = 0; i < 12 && !granted; i++) begin
            @(negedge clk);
            granted = port ? req1_ready : req0_ready;
        end
        checkOutput("req_ready_own", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
        checkOutput("req_ready_other", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
        if (granted) sb.push_back(mkExp(port, exp_result, exp_zero, exp_less));
        @(posedge clk);
        #1;
        if (port == 1'b0) req0_valid = 1'b0;
        else              req1_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain_queue", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every response handshake against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            checkOutput("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_rsp: got port %0d result %h, expected no response",
                             rsp1_valid, rsp_result);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_port",   {31'd0, rsp1_valid}, {31'd0, e.port});
                    checkOutput("rsp_result", rsp_result, e.result);
                    checkOutput("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
                    checkOutput("rsp_less",   {31'd0, rsp_less}, {31'd0, e.less});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        int grants;
        int cyc;
        int last_cyc;
        int fx_grants;
        logic exp_port;

        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctr = '0;
        req1_a = '0; req1_b = '0; req1_ctr = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        #3;
        checkOutput("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        checkOutput("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        checkOutput("reset_result", rsp_result, 32'd0);
        checkOutput("reset_flags", {30'd0, rsp_zero, rsp_less}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie with round-robin on dut, fixed priority on dut_fx.
        req0_a = 32'd3;    req0_b = 32'd3;    req0_ctr = 4'b1000;
        req1_a = 32'h0000_00FF; req1_b = 32'h0000_000F; req1_ctr = 4'b0100;
        req0_valid = 1'b1; req1_valid = 1'b1;
        grants = 0; cyc = 0; last_cyc = 0; fx_grants = 0;
        while (grants < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            checkOutput("fx_req1_ready", {31'd0, fx_req1_ready}, 32'd0);
            checkOutput("fx_rsp1_valid", {31'd0, fx_rsp1_valid}, 32'd0);
            if (fx_rsp0_valid) begin
                checkOutput("fx_result", fx_rsp_result, 32'd0);
                checkOutput("fx_zero", {31'd0, fx_rsp_zero}, 32'd1);
            end
            if (fx_req0_ready) fx_grants++;
            if (req0_ready || req1_ready) begin
                exp_port = grants[0];
                checkOutput("tie_grant_port", {31'd0, req1_ready}, {31'd0, exp_port});
                checkOutput("tie_grant_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
                if (grants > 0) checkOutput("tie_spacing", cyc - last_cyc, 32'd3);
                if (exp_port == 1'b0) sb.push_back(mkExp(1'b0, 32'd0, 1'b1, 1'b0));
                else                  sb.push_back(mkExp(1'b1, 32'h0000_00F0, 1'b0, 1'b0));
                grants++;
                last_cyc = cyc;
            end
        end
        checkOutput("tie_grant_count", grants, 32'd4);
        checkOutput("fx_grant_count", fx_grants, 32'd4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        waitDrain();

        // Single add with latency check.
        applyStimulus(1'b0, 32'd5, 32'd7, 4'b0000, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("lat_exec_rsp0", {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        checkOutput("lat_resp_rsp0", {31'd0, rsp0_valid}, 32'd1);
        waitDrain();

        // Directed op vectors.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 32'h8000_0000, 32'd4, 4'b1101, 32'hF800_0000, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 32'd5, 32'd5, 4'b1010, 32'd0, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(1'b0, 32'd1, 32'h0000_003F, 4'b0001, 32'h8000_0000, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(1'b0, 32'd1, 32'h1234_5000, 4'b1011, 32'h1234_5000, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 32'h0000_F0F0, 32'h0000_FF00, 4'b1111, 32'h0000_F000, 1'b0, 1'b0);
        waitDrain();

        // Backpressure on port 1 while port 0 waits.
        rsp1_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_00FF, 32'h0000_000F, 4'b0100, 32'h0000_00F0, 1'b0, 1'b0);
        req0_a = 32'd1; req0_b = 32'd2; req0_ctr = 4'b0000; req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            checkOutput("bp_result_hold", rsp_result, 32'h0000_00F0);
            checkOutput("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp1_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_hs_req0_ready", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        checkOutput("bp_after_req0_ready", {31'd0, req0_ready}, 32'd1);
        if (req0_ready) sb.push_back(mkExp(1'b0, 32'd3, 1'b0, 1'b0));
        @(posedge clk);
        #1 req0_valid = 1'b0;
        waitDrain();

        // Reset during EXEC: the in-flight op must vanish.
        req0_a = 32'd9; req0_b = 32'd9; req0_ctr = 4'b0000; req0_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_pre_grant", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valids", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        checkOutput("rst_result", rsp_result, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rst_no_stale", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        req0_a = 32'd2; req0_b = 32'd2; req0_ctr = 4'b0000;
        req1_a = 32'd8; req1_b = 32'd1; req1_ctr = 4'b1000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_tie_req0", {31'd0, req0_ready}, 32'd1);
        checkOutput("rst_tie_req1", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) sb.push_back(mkExp(1'b0, 32'd4, 1'b0, 1'b0));
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational RV32I ALU between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1). Each port has a valid/ready operation channel and a valid/ready response channel. The block arbitrates round-robin, registers the winning operands, evaluates them through one `alu` instance, and holds the registered result until the owning port accepts it. One operation is in flight at a time.

## Interface
- `RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  an operation is offered on the port.
- `req0_ready`, `req1_ready`  out  1  the operation is accepted this cycle.
- `req0_a`, `req1_a`  in  32  operand A.
- `req0_b`, `req1_b`  in  32  operand B; for shifts only bits [4:0] are used.
- `req0_ctr`, `req1_ctr`  in  4  ALU control code (see package constants).
- `rsp0_valid`, `rsp1_valid`  out  1  the port's result is available.
- `rsp0_ready`, `rsp1_ready`  in  1  the port consumes its result.
- `rsp_result`  out  32  registered ALU output, shared by both ports.
- `rsp_zero`  out  1  registered Zero flag.
- `rsp_less`  out  1  registered Less flag.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - No request valid: stay in IDLE.
  - Otherwise select a winner `w`:
    - RR=1: if both ports are valid, `w` = the port not granted last.
    - RR=0: if both ports are valid, `w` = 0.
    - A single valid port always wins.
  - Assert `reqw_ready` combinationally in the same cycle; it is never asserted for the loser.
  - On the clock edge: latch a, b, ctr and owner = `w`; update `last_grant` = `w`; go to EXEC.
- **EXEC**
  - The `alu` instance is driven only from the latched registers.
  - On the clock edge: capture ALUout, Zero and Less into the result registers; go to RESP.
- **RESP**
  - `rsp<owner>_valid` = 1; the other port's `rsp_valid` = 0.
  - When `rsp<owner>_ready` = 1: go to IDLE on that edge.
  - Otherwise hold every result register and `rsp_valid` stable.
- `req*_ready` is 0 in EXEC and RESP. A requester keeps valid, a, b and ctr stable until it sees ready.
- The `rsp_ready` of the non-owner port is ignored.
- **Zero flag for SLT/SLTU:** Zero reflects A−B == 0, not the output value. The bench checks this.
- All 16 `ctr` codes are defined, so there is no illegal-op path.
- **Reset values:** state = IDLE, `last_grant` = 1 (so port 0 wins the first tie), operand and result registers = 0, all `rsp_valid` = 0.
- **Reset mid-operation:** the in-flight operation is discarded. No response is produced for it.

## Timing
- Accept edge at cycle N (`req_ready` & `req_valid` high in cycle N).
- The EXEC state occupies cycle N+1; `rsp_valid` is high from cycle N+2.
- Minimum spacing between accepts on any ports is 3 cycles, reached when `rsp_ready` is held high.
- `req_ready` depends combinationally on both `req_valid` inputs and the state. There is no path from `req_*` to `rsp_*` within a cycle.
- **Simultaneous events:**
  - A new request arriving in RESP waits; it can be accepted in the IDLE cycle that follows the response handshake.
  - A request that drops valid before being granted is not remembered.

## Structure
- **Package `alu_pkg`** holds:
  - `ALU_ADD` = 0000, `ALU_SUB` = 1000.
  - `ALU_OR` = 0110/1110, `ALU_AND` = 0111/1111, `ALU_XOR` = 0100/1100.
  - `ALU_SLT` = 0010, `ALU_SLTU` = 1010.
  - `ALU_SLL` = 0001/1001, `ALU_LUI` (copy B) = 0011/1011.
  - `ALU_SRL` = 0101, `ALU_SRA` = 1101.
  - The FSM state enum: IDLE = 0, EXEC = 1, RESP = 2.
- **Sub-module:** exactly one, the existing `alu` (inputs A, B, ALUctr; outputs ALUout, Zero, Less), instantiated once. The arbitration logic stays inline.

## Test plan
- **Single add:** port 0 offers a = 5, b = 7, ctr = 0000 → `req0_ready` in the same cycle; two cycles later `rsp0_valid` = 1 with result = 12, zero = 0, less = 0.
- **Tie, round-robin:** RR=1, both ports valid every cycle, port 0 SUB 3−3 and port 1 XOR FF^0F, `rsp_ready` tied high → grants alternate 0,1,0,1 starting with 0. Port 0 gets result = 0 with zero = 1; port 1 gets result = F0. Accepts are 3 cycles apart.
- **Signed vs unsigned compare:** SLT with a = FFFFFFFF, b = 1 → result = 1, less = 1. SLTU with the same operands → result = 0, less = 0, zero = 0. SRA of 80000000 by 4 → F8000000.
- **Backpressure:** `rsp1_ready` held low for 5 cycles → `rsp1_valid` and `rsp_result` stay stable, `req0_ready` stays 0 although port 0 is valid. Port 0 is granted in the first IDLE cycle after the response handshake.
- **Fixed priority:** RR=0, both ports continuously valid → only port 0 is ever granted.
- **Reset mid-operation:** `rst_n` pulsed low asynchronously during EXEC → state = IDLE, all `rsp_valid` = 0 immediately, and no stale response appears after release. The first tie after release is granted to port 0.
